// File: rtl/energy_accumulator_pkg.sv
// Shared types and constants for the energy accumulator: FSM encoding, default sizes
// and the saturation ceiling helper.
package energy_accumulator_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StAcc  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned DefaultAccW   = 24;
    localparam int unsigned DefaultWinLen = 16;
    localparam int unsigned CntW          = 8;

    // Largest value representable in w bits; callers narrow it to their own width.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/energy_accumulator_if.sv
// Sample handshake bundle: paired voltage/current samples over valid/ready.
interface energy_accumulator_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] volt;
    logic [7:0] curr;

    modport master (
        output in_valid,
        output volt,
        output curr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  volt,
        input  curr,
        output in_ready
    );

endinterface

// File: rtl/energy_accumulator_mul.sv
// Unsigned 8x8 combinational multiplier with a full 16-bit product.
module energy_accumulator_mul (
    input  logic [7:0]  i1_i,
    input  logic [7:0]  i2_i,
    output logic [15:0] p_o
);

    assign p_o = {8'd0, i1_i} * {8'd0, i2_i};

endmodule

// File: rtl/energy_accumulator.sv
// Windowed energy metering: multiplies sample pairs, accumulates with saturation over
// WIN_LEN samples, publishes the window energy and raises a sticky over-limit alarm.
module energy_accumulator
    import energy_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W   = DefaultAccW,
    parameter int unsigned WIN_LEN = DefaultWinLen
) (
    input  logic                 clk,
    input  logic                 rst,
    energy_accumulator_if.slave  sample,
    input  logic [ACC_W-1:0]     thresh,
    input  logic                 clear,
    output logic [ACC_W-1:0]     energy,
    output logic                 win_done,
    output logic                 over_limit,
    output logic                 busy
);

    localparam logic [ACC_W-1:0] AccMax  = ACC_W'(sat_max(ACC_W));
    localparam logic [CntW-1:0]  WinLenC = CntW'(WIN_LEN);

    state_e            state_q;
    logic [7:0]        volt_q;
    logic [7:0]        curr_q;
    logic [15:0]       prod;
    logic [15:0]       prod_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_next;
    logic [CntW-1:0]   win_cnt_q;
    logic [CntW-1:0]   cnt_next;
    logic [ACC_W-1:0]  energy_q;
    logic              win_done_q;
    logic              over_limit_q;

    energy_accumulator_mul u_multiplier_8 (
        .i1_i (volt_q),
        .i2_i (curr_q),
        .p_o  (prod)
    );

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    assign acc_sum  = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_q};
    assign acc_next = acc_sum[ACC_W] ? AccMax : acc_sum[ACC_W-1:0];
    assign cnt_next = win_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            volt_q       <= '0;
            curr_q       <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            energy_q     <= '0;
            win_done_q   <= 1'b0;
            over_limit_q <= 1'b0;
        end else if (clear) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            win_done_q   <= 1'b0;
            over_limit_q <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sample.in_valid) begin
                        volt_q  <= sample.volt;
                        curr_q  <= sample.curr;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    prod_q  <= prod;
                    state_q <= StAcc;
                end
                StAcc: begin
                    if (cnt_next == WinLenC) begin
                        // Publish alongside win_done so energy is valid during the pulse.
                        energy_q   <= acc_next;
                        win_done_q <= 1'b1;
                        if (acc_next > thresh) begin
                            over_limit_q <= 1'b1;
                        end
                        acc_q     <= '0;
                        win_cnt_q <= '0;
                        state_q   <= StDone;
                    end else begin
                        acc_q     <= acc_next;
                        win_cnt_q <= cnt_next;
                        state_q   <= StIdle;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sample.in_ready = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign energy          = energy_q;
    assign over_limit      = over_limit_q;
    // A clear landing on the DONE cycle suppresses the pulse.
    assign win_done        = win_done_q & ~clear;

endmodule

// File: tb/tb_energy_accumulator.sv
// Scoreboard bench for energy_accumulator across three parameterisations.
module tb_energy_accumulator;

    typedef struct {
        int          id;
        logic [31:0] energy;
        logic        over;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  valid;
    logic [2:0]  clr;
    logic [2:0]  rdy;
    logic [2:0]  done;
    logic [2:0]  over;
    logic [2:0]  bsy;
    logic [7:0]  volt [3];
    logic [7:0]  curr [3];
    logic [23:0] thr [3];
    logic [23:0] en [3];
    logic [15:0] en_c;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    energy_accumulator_if sif0 ();
    energy_accumulator_if sif1 ();
    energy_accumulator_if sif2 ();

    assign sif0.in_valid = valid[0];
    assign sif0.volt     = volt[0];
    assign sif0.curr     = curr[0];
    assign rdy[0]        = sif0.in_ready;
    assign sif1.in_valid = valid[1];
    assign sif1.volt     = volt[1];
    assign sif1.curr     = curr[1];
    assign rdy[1]        = sif1.in_ready;
    assign sif2.in_valid = valid[2];
    assign sif2.volt     = volt[2];
    assign sif2.curr     = curr[2];
    assign rdy[2]        = sif2.in_ready;
    assign en[2]         = {8'd0, en_c};

    energy_accumulator #(.ACC_W(24), .WIN_LEN(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .sample     (sif0),
        .thresh     (thr[0]),
        .clear      (clr[0]),
        .energy     (en[0]),
        .win_done   (done[0]),
        .over_limit (over[0]),
        .busy       (bsy[0])
    );

    energy_accumulator #(.ACC_W(24), .WIN_LEN(16)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .sample     (sif1),
        .thresh     (thr[1]),
        .clear      (clr[1]),
        .energy     (en[1]),
        .win_done   (done[1]),
        .over_limit (over[1]),
        .busy       (bsy[1])
    );

    energy_accumulator #(.ACC_W(16), .WIN_LEN(4)) u_dut_c (
        .clk        (clk),
        .rst        (rst),
        .sample     (sif2),
        .thresh     (thr[2][15:0]),
        .clear      (clr[2]),
        .energy     (en_c),
        .win_done   (done[2]),
        .over_limit (over[2]),
        .busy       (bsy[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_acc(input logic [31:0] acc, input int v, input int c,
                                            input int w);
        longint sum;
        longint lim;
        sum = longint'(acc) + longint'(v * c);
        lim = (64'd1 << w) - 1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    // Called on a negedge; leaves valid high and returns on the negedge after the handshake.
    task automatic send(input int idx, input logic [7:0] v, input logic [7:0] c,
                        output int waited);
        valid[idx] = 1'b1;
        volt[idx]  = v;
        curr[idx]  = c;
        waited     = 0;
        while (rdy[idx] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check_eq("handshake timeout", waited, 0);
        @(negedge clk);
    endtask

    task automatic wait_done(input int idx, output int lat);
        lat = 0;
        while (done[idx] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_window(input int idx, input int n, input logic [7:0] v,
                              input logic [7:0] c, input string tag);
        int w;
        int lat;
        for (int k = 0; k < n; k++) begin
            send(idx, v, c, w);
        end
        valid[idx] = 1'b0;
        wait_done(idx, lat);
        check_eq({tag, " latency"}, lat, 2);
        @(negedge clk);
        check_eq({tag, " pulse width"}, done[idx], 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq($sformatf("win_done%0d expected entry", i), sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq($sformatf("win_done%0d instance", i), i, mon_e.id);
                    check_eq($sformatf("energy%0d", i), en[i], mon_e.energy);
                    check_eq($sformatf("over_limit%0d at close", i), over[i], mon_e.over);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        int w;
        int lat;

        rst = 1'b1;
        valid = '0;
        clr = '0;
        for (int i = 0; i < 3; i++) begin
            volt[i] = '0;
            curr[i] = '0;
            thr[i]  = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset in_ready%0d", i), rdy[i], 1);
            check_eq($sformatf("reset busy%0d", i), bsy[i], 0);
            check_eq($sformatf("reset win_done%0d", i), done[i], 0);
            check_eq($sformatf("reset over%0d", i), over[i], 0);
            check_eq($sformatf("reset energy%0d", i), en[i], 0);
        end

        // Single-sample windows: basic product, strict compare at equality, alarm set.
        thr[0] = 24'd30000;
        sb.push_back('{0, 32'd20000, 1'b0});
        send(0, 8'd200, 8'd100, w);
        valid[0] = 1'b0;
        check_eq("busy in MUL", bsy[0], 1);
        check_eq("in_ready in MUL", rdy[0], 0);
        wait_done(0, lat);
        check_eq("a latency", lat, 2);
        @(negedge clk);
        check_eq("a pulse width", done[0], 0);
        check_eq("a back to idle", rdy[0], 1);

        thr[0] = 24'd20000;
        sb.push_back('{0, 32'd20000, 1'b0});
        run_window(0, 1, 8'd200, 8'd100, "a equal");
        check_eq("equal thresh no alarm", over[0], 0);

        thr[0] = 24'd30000;
        sb.push_back('{0, 32'd40000, 1'b1});
        run_window(0, 1, 8'd200, 8'd200, "a over");

        // Clear during DONE: pulse suppressed and alarm dropped.
        send(0, 8'd10, 8'd10, w);
        valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr[0] = 1'b1;
        @(negedge clk);
        check_eq("clear masks win_done", done[0], 0);
        @(negedge clk);
        clr[0] = 1'b0;
        check_eq("clear drops alarm", over[0], 0);
        check_eq("clear idle", rdy[0], 1);

        // 16 back-to-back samples: in_ready 1,0,0 cadence.
        thr[1] = 24'd2000000;
        exp = 0;
        for (int k = 0; k < 16; k++) exp = sat_acc(exp, 255, 255, 24);
        sb.push_back('{1, exp, 1'b0});
        for (int k = 0; k < 16; k++) begin
            send(1, 8'd255, 8'd255, w);
            check_eq($sformatf("b ready wait %0d", k), w, (k == 0) ? 0 : 2);
        end
        valid[1] = 1'b0;
        wait_done(1, lat);
        check_eq("b latency", lat, 2);
        @(negedge clk);
        check_eq("b pulse width", done[1], 0);

        // Saturation at 16 bits, sticky alarm across a zero window.
        thr[2] = 24'd60000;
        exp = 0;
        for (int k = 0; k < 4; k++) exp = sat_acc(exp, 255, 255, 16);
        sb.push_back('{2, exp, 1'b1});
        run_window(2, 4, 8'd255, 8'd255, "c sat");
        sb.push_back('{2, 32'd0, 1'b1});
        run_window(2, 4, 8'd0, 8'd0, "c zero");
        check_eq("c alarm sticky", over[2], 1);
        sb.push_back('{2, exp, 1'b1});
        run_window(2, 4, 8'd255, 8'd255, "c sat2");

        // Partial window, then clear: count restarts, energy retained.
        for (int k = 0; k < 2; k++) send(2, 8'd10, 8'd10, w);
        valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        check_eq("c clear alarm", over[2], 0);
        check_eq("c clear keeps energy", en[2], exp);
        check_eq("c clear idle", bsy[2], 0);
        exp = 0;
        for (int k = 0; k < 4; k++) exp = sat_acc(exp, 1, 2, 16);
        sb.push_back('{2, exp, 1'b0});
        run_window(2, 4, 8'd1, 8'd2, "c after clear");

        // Reset landing in ACC mid-window.
        for (int k = 0; k < 7; k++) send(1, 8'd10, 8'd10, w);
        valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst energy", en[1], 0);
        check_eq("rst win_done", done[1], 0);
        check_eq("rst over", over[1], 0);
        check_eq("rst busy", bsy[1], 0);
        check_eq("rst in_ready", rdy[1], 1);
        exp = 0;
        for (int k = 0; k < 16; k++) exp = sat_acc(exp, 3, 4, 24);
        sb.push_back('{1, exp, 1'b0});
        run_window(1, 16, 8'd3, 8'd4, "b after rst");

        repeat (5) @(negedge clk);
        check_eq("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/energy_accumulator.md
Name: energy_accumulator

Overview:
Sequential power/energy metering stage for the SmartHomeSystem sensor path.
- Accepts paired 8-bit voltage and current samples over a valid/ready handshake.
- Drives them into the 8x8 combinational multiplier and registers the 16-bit product.
- Accumulates the products over a fixed sample window, publishes the window energy and flags when a programmable limit is exceeded.

Parameters:
ACC_W, 24, accumulator and energy output width in bits; must be at least 16.
WIN_LEN, 16, number of samples per accumulation window; range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample pair present on volt/curr
in_ready  output  1  block can accept a sample this cycle
volt  input  8  unsigned voltage sample
curr  input  8  unsigned current sample
thresh  input  ACC_W  window energy limit, sampled at window close
clear  input  1  synchronous soft clear of accumulator, window count and alarm
energy  output  ACC_W  energy of last completed window
win_done  output  1  one-cycle pulse, energy updated this cycle
over_limit  output  1  sticky alarm
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - state=IDLE; accumulator, window count, energy and operand/product registers cleared to 0.
  - win_done=0, over_limit=0, busy=0, in_ready=1 in the following cycle.
- State machine:
  - IDLE: in_ready=1. When in_valid&in_ready, register volt/curr into the operand registers and go to MUL.
  - MUL: in_ready=0. The multiplier settles on the registered operands; the 16-bit product is registered at the end of the cycle. Next state is ACC.
  - ACC: in_ready=0. acc_next = acc + zero-extended product, saturating at 2^ACC_W-1 with no wrap. Increment win_cnt.
    - If win_cnt reaches WIN_LEN: go to DONE.
    - Otherwise: return to IDLE.
  - DONE: energy <= acc_next value, win_done=1 for this cycle only, acc <= 0, win_cnt <= 0.
    - If the window energy > thresh (strict compare), set over_limit. It stays set until clear or rst.
    - Next state is IDLE.
- Throughput and latency:
  - One sample per 3 cycles.
  - The window-closing sample takes 4 cycles.
  - win_done is asserted exactly 3 cycles after the handshake of the WIN_LEN-th sample.
- Outputs:
  - energy holds its value between windows.
  - busy = (state != IDLE).
- clear:
  - Has the same effect as rst on the accumulator, win_cnt, over_limit and state.
  - energy is NOT cleared.
  - An in-flight sample is discarded.
  - win_done is forced 0 if clear coincides with DONE.
- Priority: rst > clear > normal operation.
- A handshake in the same cycle as clear is ignored, because clear forces IDLE with an empty pipeline.
- in_valid while in_ready=0: no effect. The source must hold data until the handshake.
- Saturation: once acc hits its maximum it stays there until the window closes; the published energy is the saturated maximum.
- WIN_LEN=1: every sample produces a window (IDLE→MUL→ACC→DONE).

Decomposition:
- Shared constants header holds:
  - state encodings: IDLE=2'd0, MUL=2'd1, ACC=2'd2, DONE=2'd3;
  - default ACC_W and WIN_LEN;
  - the saturation maximum macro.
- One sub-module instance: Multiplier_8 (I1=operand volt register, I2=operand curr register, P=product).
- FSM, counter, saturating adder and alarm logic stay in this module.

Test Plan:
- Reset then single sample volt=200, curr=100 with WIN_LEN=1 -> win_done pulses 3 cycles after handshake; energy=20000; over_limit=0 with thresh=30000.
- 16 samples of 255×255, back-to-back in_valid -> in_ready pattern 1,0,0 repeating; energy=1040400 after the 16th; win_done single-cycle.
- ACC_W=16, WIN_LEN=4, samples 255×255 -> energy saturates at 65535 with no wrap; thresh=60000 -> over_limit=1 and stays high across the next window of zeros.
- over_limit set, then clear pulse -> over_limit=0, energy unchanged, next window starts counting from sample 1.
- rst asserted while in ACC mid-window (e.g. after 7 samples of 10×10) -> next cycle all outputs 0, in_ready=1; a following full window gives energy from fresh samples only.
- Boundary compare: window energy exactly equal to thresh (e.g. thresh=20000, one sample 200×100, WIN_LEN=1) -> over_limit stays 0.
